ps2_key_rx: RTL
===============

Name: ps2_key_rx

Overview:
- PS/2 keyboard receiver that produces the 11-bit `ps2_key` event word consumed by the arcade top-level input decoders.
- Receives device-to-host PS/2 frames from the raw clock/data pins.
- Folds 0xE0 (extended) and 0xF0 (break) prefixes into a single key event, and announces each event by flipping a toggle bit.
- Sits between the keyboard pins and the per-game button latches; all logic runs in the `clk_sys` domain.

Parameters:
- FILT_LEN, 8: consecutive identical `clk_sys` samples required before the filtered `ps2_clk` level changes.
- TIMEOUT, 24000: `clk_sys` cycles without a falling edge, while mid-frame, that abort the frame (about 500 us at 48 MHz).
- TO_W, 15: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous
- ps2_dat  in  1  raw PS/2 data pin, asynchronous
- ps2_key  out  11  [10] event toggle, [9] pressed (1 = make), [8] extended, [7:0] scan code
- byte_stb  out  1  one-cycle pulse for every valid received byte
- byte_dat  out  8  last valid received byte
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error

Behaviour:
- Reset values (held while `reset` is high): `ps2_key` = 0, `byte_dat` = 0, `byte_stb` = 0, `frame_err` = 0. Reset also sets the receive FSM to IDLE, clears the ext and brk flags and the skip counter, and sets the filter to level 1.
- Input conditioning:
  - Both pins pass through a 2-flop synchronizer.
  - Filtered clock level changes only after FILT_LEN consecutive equal samples.
  - A falling edge (`fall`) is a 1-cycle pulse on a filtered 1->0 transition.
  - Data is sampled from the synchronized `ps2_dat` on the `fall` cycle.
- Receive FSM:
  - IDLE: on `fall` with dat = 0 (start bit), go to DATA with bit counter = 0. On `fall` with dat = 1, stay in IDLE with no error.
  - DATA: on each `fall`, shift dat into `shreg` LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is valid iff dat = 1 and XOR(data, parity) = 1 (odd parity).
    - Valid frame: `byte_stb` = 1 and `byte_dat` = data on the next cycle, then pass the byte to the decoder.
    - Invalid frame: `frame_err` pulse, clear ext, brk and skip.
    - Either way, return to IDLE.
- Timeout:
  - The counter resets on every `fall` and whenever the FSM is in IDLE.
  - In any non-IDLE state, when the counter reaches TIMEOUT: `frame_err` pulse, FSM to IDLE, flags cleared, no byte delivered.
- Decoder, applied per valid byte in priority order:
  1. If skip != 0: decrement skip, drop the byte.
  2. 0xE1: skip = 7 (Pause sequence discarded), clear ext and brk.
  3. 0xE0: set ext.
  4. 0xF0: set brk.
  5. With ext = 0 and brk = 0, bytes 0xAA, 0xFA, 0xEE, 0xFE, 0xFC, 0x00, 0xFF are dropped (keyboard responses).
  6. Otherwise emit `ps2_key` <= {~ps2_key[10], ~brk, ext, byte} and clear ext and brk.
- Latency: `ps2_key` updates on the same cycle `byte_stb` is asserted, i.e. 2 cycles after the `fall` of the stop bit.
- `byte_stb` also fires for prefix, dropped and skipped bytes; `ps2_key[10]` toggles only on emitted events.
- The prefix flags persist across frames; only an emit, an error or reset clears them.
- Reset takes priority over any simultaneous `fall` or timeout.

Test Plan:
- Send frame 0x1C (odd parity bit 0): `byte_stb` pulses with `byte_dat` = 0x1C, and `ps2_key` goes from 0x000 to 0x61C.
- Send E0, 75 then E0, F0, 75: first event is `ps2_key` = 0x375 (toggle 0, pressed, ext), second is 0x575 (toggle 1, released, ext); `ps2_key[8:0]` = 0x175 both times.
- Send 0x29 with the parity bit inverted: `frame_err` pulse, no `byte_stb`, `ps2_key` unchanged; a following valid 0x29 gives pressed = 1, ext = 0.
- Stop the PS/2 clock after 5 data bits for TIMEOUT+10 cycles: one `frame_err` pulse, FSM back in IDLE; the next full frame 0x16 is received correctly.
- Send 1-cycle and (FILT_LEN-1)-cycle glitches low on `ps2_clk` while idle: no `fall`, no state change.
- Send the Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 0x16: 9 `byte_stb` pulses and exactly one `ps2_key` event, 0x216 with the toggle flipped. Assert `reset` mid-frame: all outputs return to 0 and the next frame decodes normally.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the pins, deframes 11-bit
// device-to-host frames and folds E0/F0/E1 prefixes into an 11-bit key event word.
module ps2_key_rx #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 24000,
  parameter int TO_W     = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        byte_stb,
  output logic [7:0]  byte_dat,
  output logic        frame_err
);

  localparam int FC_W = $clog2(FILT_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]      clk_sync;
  logic [1:0]      dat_sync;
  logic            filt;
  logic [FC_W-1:0] filt_cnt;
  logic            fall;
  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par;
  logic [TO_W-1:0] to_cnt;
  logic            rx_valid;
  logic [7:0]      rx_byte;
  logic            ext;
  logic            brk;
  logic [2:0]      skip;

  wire ck  = clk_sync[1];
  wire dat = dat_sync[1];

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic logic is_response(input logic [7:0] b);
    logic r;
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Two-flop synchronizers; idle PS/2 lines sit high.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Glitch filter: filt_cnt counts consecutive samples that differ from the filtered level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (ck == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
        filt     <= ck;
        filt_cnt <= '0;
        fall     <= filt;
      end else begin
        filt_cnt <= filt_cnt + {{(FC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Frame deserializer with mid-frame timeout.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par       <= 1'b0;
      to_cnt    <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE || fall) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end
      if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            bit_cnt <= 3'd0;
            state   <= dat ? IDLE : DATA;
          end
          DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            state   <= (bit_cnt == 3'd7) ? PARITY : DATA;
          end
          PARITY: begin
            par   <= dat;
            state <= STOP;
          end
          STOP: begin
            if (dat && odd_parity_ok(shreg, par)) begin
              rx_valid <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else begin
        state <= state;
      end
    end
  end

  // Prefix/skip decoder; errors flush any partially collected sequence.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_key  <= 11'h000;
      byte_stb <= 1'b0;
      byte_dat <= 8'h00;
      ext      <= 1'b0;
      brk      <= 1'b0;
      skip     <= 3'd0;
    end else begin
      byte_stb <= rx_valid;
      if (frame_err) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= 3'd0;
      end else if (rx_valid) begin
        byte_dat <= rx_byte;
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (rx_byte == 8'hE1) begin
          skip <= 3'd7;
          ext  <= 1'b0;
          brk  <= 1'b0;
        end else if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else if (!ext && !brk && is_response(rx_byte)) begin
          skip <= skip;
        end else begin
          ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
          ext     <= 1'b0;
          brk     <= 1'b0;
        end
      end else begin
        skip <= skip;
      end
    end
  end

endmodule
